// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants for the fetch/branch-resolve slice.
// Contents: control-transfer opcodes, branch funct3 encodings, the canonical
// NOP word (addi x0,x0,0) and the RUN/FLUSH state type of the resolve unit.
package rv32i_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INS = 32'h00000013;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_compare.sv
// Combinational RV32I branch condition evaluator.
// Ports:
//   funct3  in  3   branch kind (ins[14:12])
//   rs1     in  32  first operand
//   rs2     in  32  second operand
//   taken   out 1   condition true; reserved encodings 010/011 never take
module branch_compare
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves taken
    // unassigned; otherwise synthesis infers a latch.
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves RV32I control transfers at the consumer end of fetch, drives the
// pcsrc/bjumppc redirect back to fetch, squashes the FLUSH_DEPTH wrong-path
// slots already in flight, and forwards surviving instructions to execute.
// All outputs are registered: one cycle after the input edge.
// Ports:
//   clk, reset (sync, active-low)
//   ins, current_address_out (word address), in_valid   : fetched slot
//   rs1_data, rs2_data                                   : register reads
//   pcsrc, bjumppc (word address)                        : redirect to fetch
//   out_valid, out_ins, out_pc                           : to execute
//   link_we, link_rd, link_data (byte address)           : JAL/JALR link write
//   misalign_err                                         : target bit1 set
module branch_resolve_unit #(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter logic [31:0] NOP_INS     = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic [31:0] current_address_out,
  input  logic        in_valid,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        pcsrc,
  output logic [31:0] bjumppc,
  output logic        out_valid,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  output logic        link_we,
  output logic [4:0]  link_rd,
  output logic [31:0] link_data,
  output logic        misalign_err
);

  import rv32i_pkg::OP_BRANCH;
  import rv32i_pkg::OP_JAL;
  import rv32i_pkg::OP_JALR;
  import rv32i_pkg::state_e;
  import rv32i_pkg::ST_RUN;
  import rv32i_pkg::ST_FLUSH;

  // +2 keeps the counter at least one bit wide even when FLUSH_DEPTH is 0.
  localparam int CNT_W = $clog2(FLUSH_DEPTH + 2);

  state_e             state;
  logic [CNT_W-1:0]   flush_cnt;

  logic [6:0]  opcode;
  logic        is_branch, is_jal, is_jalr, cmp_taken, taken;
  logic [31:0] imm_b, imm_j, imm_i, pc_byte, target, pc_inc;

  assign opcode    = ins[6:0];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_i = {{20{ins[31]}}, ins[31:20]};

  assign pc_byte = {current_address_out[29:0], 2'b00};
  assign pc_inc  = current_address_out + 32'd1;

  // JALR clears bit0 only; bit1 survives so a misaligned target is visible.
  assign target = is_jalr ? ((rs1_data + imm_i) & 32'hFFFF_FFFE)
                          : (pc_byte + (is_jal ? imm_j : imm_b));

  branch_compare u_branch_compare (
    .funct3 (ins[14:12]),
    .rs1    (rs1_data),
    .rs2    (rs2_data),
    .taken  (cmp_taken)
  );

  assign taken = is_jal | is_jalr | (is_branch & cmp_taken);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_RUN;
      flush_cnt    <= '0;
      pcsrc        <= 1'b0;
      bjumppc      <= '0;
      out_valid    <= 1'b0;
      out_ins      <= NOP_INS;
      out_pc       <= '0;
      link_we      <= 1'b0;
      link_rd      <= '0;
      link_data    <= '0;
      misalign_err <= 1'b0;
    end else begin
      // Strobes default low; out_ins defaults to the bubble word.
      pcsrc        <= 1'b0;
      link_we      <= 1'b0;
      misalign_err <= 1'b0;
      out_valid    <= 1'b0;
      out_ins      <= NOP_INS;
      out_pc       <= current_address_out;

      case (state)
        ST_RUN: begin
          if (in_valid) begin
            out_valid <= 1'b1;
            out_ins   <= ins;
            if (taken) begin
              pcsrc        <= 1'b1;
              bjumppc      <= {2'b00, target[31:2]};
              misalign_err <= target[1];
              if (FLUSH_DEPTH != 0) begin
                state     <= ST_FLUSH;
                flush_cnt <= CNT_W'(FLUSH_DEPTH);
              end
            end
            if (is_jal || is_jalr) begin
              link_we   <= 1'b1;
              link_rd   <= ins[11:7];
              link_data <= {pc_inc[29:0], 2'b00};
            end
          end
        end
        ST_FLUSH: begin
          // The edge that brings the counter to zero kills the last slot and
          // returns to RUN, so exactly FLUSH_DEPTH slots are dropped.
          flush_cnt <= flush_cnt - CNT_W'(1);
          if (flush_cnt == CNT_W'(1)) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios with
// hand-derived constants, then randomized traffic against a slot-level model.
module tb_branch_resolve_unit;

  localparam int          FLUSH_DEPTH = 2;
  localparam logic [31:0] NOP         = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic [31:0] current_address_out;
  logic        in_valid;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        pcsrc;
  logic [31:0] bjumppc;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic        link_we;
  logic [4:0]  link_rd;
  logic [31:0] link_data;
  logic        misalign_err;

  always #5 clk = ~clk;

  branch_resolve_unit #(.FLUSH_DEPTH(FLUSH_DEPTH), .NOP_INS(NOP)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ins                 (ins),
    .current_address_out (current_address_out),
    .in_valid            (in_valid),
    .rs1_data            (rs1_data),
    .rs2_data            (rs2_data),
    .pcsrc               (pcsrc),
    .bjumppc             (bjumppc),
    .out_valid           (out_valid),
    .out_ins             (out_ins),
    .out_pc              (out_pc),
    .link_we             (link_we),
    .link_rd             (link_rd),
    .link_data           (link_data),
    .misalign_err        (misalign_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: slots still to be killed, last redirect word.
  int          kill_left = 0;
  logic [31:0] m_bj = '0;

  // Expectations for the slot applied by the most recent cyc() call.
  logic        e_pcsrc, e_valid, e_we, e_mis;
  logic [31:0] e_bj, e_ins, e_pc, e_ldata;
  logic [4:0]  e_rd;
  logic        e_ins_chk, e_pc_chk, e_lnk_chk;

  // Applies one input slot at the falling edge, predicts the outputs from the
  // instruction-set rules, then waits until just after the capturing edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] i,
                     input logic [31:0] pc, input logic [31:0] a,
                     input logic [31:0] b);
    int          imm;
    logic [31:0] t;
    logic        tk;
    logic [6:0]  op;
    @(negedge clk);
    reset = r; in_valid = v; ins = i; current_address_out = pc;
    rs1_data = a; rs2_data = b;
    e_pcsrc = 1'b0; e_valid = 1'b0; e_we = 1'b0; e_mis = 1'b0;
    e_ins = NOP; e_pc = '0; e_rd = '0; e_ldata = '0;
    e_ins_chk = 1'b0; e_pc_chk = 1'b0; e_lnk_chk = 1'b0;
    if (!r) begin
      m_bj = '0; kill_left = 0;
      e_ins_chk = 1'b1; e_pc_chk = 1'b1; e_lnk_chk = 1'b1;
    end else if (kill_left > 0) begin
      kill_left--;
      e_ins_chk = 1'b1;
    end else if (v) begin
      op = i[6:0]; tk = 1'b0; t = '0; imm = 0;
      e_valid = 1'b1; e_ins = i; e_ins_chk = 1'b1; e_pc = pc; e_pc_chk = 1'b1;
      if (op == 7'h63) begin
        case (i[14:12])
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) <  $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a <  b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        imm = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32
              + int'(i[11:8]) * 2;
        t = pc * 32'd4 + 32'(imm);
      end else if (op == 7'h6f) begin
        tk = 1'b1;
        imm = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096
              + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        t = pc * 32'd4 + 32'(imm);
      end else if (op == 7'h67) begin
        tk = 1'b1;
        imm = (i[31] ? -2048 : 0) + int'(i[30:20]);
        t = (a + 32'(imm)) & 32'hFFFF_FFFE;
      end
      if (tk) begin
        e_pcsrc = 1'b1; m_bj = t / 32'd4; e_mis = t[1]; kill_left = FLUSH_DEPTH;
      end
      if (op == 7'h6f || op == 7'h67) begin
        e_we = 1'b1; e_lnk_chk = 1'b1; e_rd = i[11:7]; e_ldata = (pc + 32'd1) * 32'd4;
      end
    end
    e_bj = m_bj;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 32'h00208863, 32'd5, 32'd7, 32'd7);
    total++; if (pcsrc !== 1'b0) begin bad++; $display("FAIL reset_pcsrc got=%0h exp=0", pcsrc); end
    total++; if (bjumppc !== 32'd0) begin bad++; $display("FAIL reset_bjumppc got=%h exp=0", bjumppc); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    total++; if (out_ins !== NOP) begin bad++; $display("FAIL reset_out_ins got=%h exp=%h", out_ins, NOP); end
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    total++; if ({link_we, link_rd, link_data, misalign_err} !== '0) begin
      bad++; $display("FAIL reset_link_misalign got=%0h/%0h/%h/%0h exp=0", link_we, link_rd, link_data, misalign_err);
    end
    cyc(1'b1, 1'b1, 32'h00000033, 32'd3, 32'd0, 32'd0);
    total++; if (out_valid !== 1'b1 || out_ins !== 32'h00000033 || out_pc !== 32'd3) begin
      bad++; $display("FAIL reset_release got=%0h/%h/%h exp=1/00000033/00000003", out_valid, out_ins, out_pc);
    end
  endtask

  task automatic test_beq_flush();
    cyc(1'b1, 1'b1, 32'h00208863, 32'd5, 32'd7, 32'd7);
    total++; if (pcsrc !== 1'b1 || bjumppc !== 32'd9 || out_valid !== 1'b1) begin
      bad++; $display("FAIL beq_taken got=%0h/%h/%0h exp=1/00000009/1", pcsrc, bjumppc, out_valid);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 32'h00000033, 32'(6 + k), 32'd0, 32'd0);
      total++; if (out_valid !== 1'b0 || pcsrc !== 1'b0 || out_ins !== NOP) begin
        bad++; $display("FAIL beq_kill%0d got=%0h/%0h/%h exp=0/0/%h", k, out_valid, pcsrc, out_ins, NOP);
      end
    end
    cyc(1'b1, 1'b1, 32'h00000033, 32'd8, 32'd0, 32'd0);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'd8 || bjumppc !== 32'd9) begin
      bad++; $display("FAIL beq_resume got=%0h/%h/%h exp=1/00000008/00000009", out_valid, out_pc, bjumppc);
    end
  endtask

  task automatic test_bne();
    cyc(1'b1, 1'b1, 32'h00208863, 32'd5, 32'd7, 32'd8);
    total++; if (pcsrc !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL beq_not_taken got=%0h/%0h exp=0/1", pcsrc, out_valid);
    end
    cyc(1'b1, 1'b1, 32'h00209863, 32'd5, 32'd7, 32'd7);
    total++; if (pcsrc !== 1'b0) begin bad++; $display("FAIL bne_equal got=%0h exp=0", pcsrc); end
    cyc(1'b1, 1'b1, 32'h00209863, 32'd5, 32'd7, 32'd8);
    total++; if (pcsrc !== 1'b1 || bjumppc !== 32'd9) begin
      bad++; $display("FAIL bne_taken got=%0h/%h exp=1/00000009", pcsrc, bjumppc);
    end
    cyc(1'b1, 1'b0, 32'h0, 32'd0, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_jal();
    cyc(1'b1, 1'b1, 32'hFF9FF0EF, 32'd20, 32'd0, 32'd0);
    total++; if (pcsrc !== 1'b1 || bjumppc !== 32'd18 || misalign_err !== 1'b0) begin
      bad++; $display("FAIL jal_redirect got=%0h/%h/%0h exp=1/00000012/0", pcsrc, bjumppc, misalign_err);
    end
    total++; if (link_we !== 1'b1 || link_rd !== 5'd1 || link_data !== 32'h54) begin
      bad++; $display("FAIL jal_link got=%0h/%0h/%h exp=1/1/00000054", link_we, link_rd, link_data);
    end
    cyc(1'b1, 1'b1, 32'hFF9FF0EF, 32'd21, 32'd0, 32'd0);
    total++; if (link_we !== 1'b0 || pcsrc !== 1'b0) begin
      bad++; $display("FAIL jal_one_shot got=%0h/%0h exp=0/0", link_we, pcsrc);
    end
    cyc(1'b1, 1'b0, 32'h0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_jalr_misalign();
    cyc(1'b1, 1'b1, 32'h00628067, 32'd40, 32'h100, 32'd0);
    total++; if (pcsrc !== 1'b1 || bjumppc !== 32'h41 || misalign_err !== 1'b1) begin
      bad++; $display("FAIL jalr_target got=%0h/%h/%0h exp=1/00000041/1", pcsrc, bjumppc, misalign_err);
    end
    total++; if (link_we !== 1'b1 || link_rd !== 5'd0 || link_data !== 32'hA4) begin
      bad++; $display("FAIL jalr_link got=%0h/%0h/%h exp=1/0/000000a4", link_we, link_rd, link_data);
    end
    cyc(1'b1, 1'b1, 32'h00628067, 32'd41, 32'h100, 32'd0);
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL jalr_pulse got=%0h exp=0", misalign_err); end
    cyc(1'b1, 1'b0, 32'h0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_signed_and_flush_ignore();
    cyc(1'b1, 1'b1, 32'h0020C863, 32'd5, 32'hFFFF_FFFF, 32'd1);
    total++; if (pcsrc !== 1'b1 || bjumppc !== 32'd9) begin
      bad++; $display("FAIL blt_taken got=%0h/%h exp=1/00000009", pcsrc, bjumppc);
    end
    cyc(1'b1, 1'b1, 32'h0020C863, 32'd100, 32'hFFFF_FFFF, 32'd1);
    total++; if (pcsrc !== 1'b0 || out_valid !== 1'b0 || bjumppc !== 32'd9) begin
      bad++; $display("FAIL flush_ignore got=%0h/%0h/%h exp=0/0/00000009", pcsrc, out_valid, bjumppc);
    end
    cyc(1'b1, 1'b1, 32'h00000033, 32'd101, 32'd0, 32'd0);
    cyc(1'b1, 1'b1, 32'h0020E863, 32'd5, 32'hFFFF_FFFF, 32'd1);
    total++; if (pcsrc !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bltu_not_taken got=%0h/%0h exp=0/1", pcsrc, out_valid);
    end
  endtask

  task automatic test_reset_mid_flush();
    cyc(1'b1, 1'b1, 32'h00208863, 32'd5, 32'd3, 32'd3);
    cyc(1'b0, 1'b1, 32'h00208863, 32'd6, 32'd3, 32'd3);
    total++; if (pcsrc !== 1'b0 || out_valid !== 1'b0 || bjumppc !== 32'd0) begin
      bad++; $display("FAIL midflush_reset got=%0h/%0h/%h exp=0/0/0", pcsrc, out_valid, bjumppc);
    end
    cyc(1'b1, 1'b1, 32'h00000033, 32'd7, 32'd0, 32'd0);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'd7) begin
      bad++; $display("FAIL midflush_run got=%0h/%h exp=1/00000007", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, i, a, b;
    logic [6:0]  op;
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 7'h63;
        4:          op = 7'h6f;
        5:          op = 7'h67;
        6:          op = 7'h13;
        default:    op = 7'h33;
      endcase
      i = {r[31:7], op};
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0), i, $urandom, a, b);
      total++; if (pcsrc !== e_pcsrc) begin bad++; $display("FAIL rand%0d_pcsrc got=%0h exp=%0h", n, pcsrc, e_pcsrc); end
      total++; if (bjumppc !== e_bj) begin bad++; $display("FAIL rand%0d_bjumppc got=%h exp=%h", n, bjumppc, e_bj); end
      total++; if (out_valid !== e_valid) begin bad++; $display("FAIL rand%0d_out_valid got=%0h exp=%0h", n, out_valid, e_valid); end
      total++; if (misalign_err !== e_mis) begin bad++; $display("FAIL rand%0d_misalign got=%0h exp=%0h", n, misalign_err, e_mis); end
      total++; if (link_we !== e_we) begin bad++; $display("FAIL rand%0d_link_we got=%0h exp=%0h", n, link_we, e_we); end
      if (e_ins_chk) begin
        total++; if (out_ins !== e_ins) begin bad++; $display("FAIL rand%0d_out_ins got=%h exp=%h", n, out_ins, e_ins); end
      end
      if (e_pc_chk) begin
        total++; if (out_pc !== e_pc) begin bad++; $display("FAIL rand%0d_out_pc got=%h exp=%h", n, out_pc, e_pc); end
      end
      if (e_lnk_chk) begin
        total++; if (link_rd !== e_rd || link_data !== e_ldata) begin
          bad++; $display("FAIL rand%0d_link got=%0h/%h exp=%0h/%h", n, link_rd, link_data, e_rd, e_ldata);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; ins = '0; current_address_out = '0;
    rs1_data = '0; rs2_data = '0;
    test_reset();
    test_beq_flush();
    test_bne();
    test_jal();
    test_jalr_misalign();
    test_signed_and_flush_ignore();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
